spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
Shares one SPI controller between NREQ independent requesters (register-bank writer, DMA, debug port, ...).
Round-robin arbitration selects one requester at a time and drives the controller's configuration and handshake inputs (SPE, MSTR, ctrl_control, SPTEF, reg_addr, reg_wdata) for one master transfer.
It then waits for TXC, returns the received byte, and signals done or timeout to the owning requester.
Sits between the requester fabric and the SPI controller, in the divided-clock domain.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA, 8, data width, matches the controller data width
ADDR, 3, configuration address width
TIMEOUT, 255, max XFER cycles before abort (1..65535); counter width = clog2(TIMEOUT+1)

Ports:
CLK  in  1  divided SPI clock
PRESETn  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester transfer request, level
req_addr  in  NREQ*ADDR  packed config address, requester i at [i*ADDR +: ADDR]
req_wdata  in  NREQ*DATA  packed write data, requester i at [i*DATA +: DATA]
gnt  out  NREQ  one-hot grant, held for the whole transaction
done  out  NREQ  one-cycle completion pulse to the granted requester
err  out  NREQ  one-cycle timeout pulse to the granted requester
rdata  out  DATA  last received byte, valid from the done pulse until the next done
busy  out  1  high in any state other than IDLE
spe  out  1  to controller SPE
mstr  out  1  to controller MSTR
ctrl_control  out  1  to controller ctrl_control
sptef  out  1  to controller SPTEF
reg_addr  out  ADDR  to controller reg_addr
reg_wdata  out  DATA  to controller reg_wdata
txc  in  1  from controller TXC
m_rdata  in  DATA  from controller reg_rdata

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, counter=0, all outputs 0.
- States: IDLE, GRANT, XFER, DONE. All outputs are registered.
- IDLE:
  - Search req starting at rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - Latch the winner's idx, addr and wdata. Next state GRANT.
  - No req set: stay in IDLE.
- GRANT (1 cycle):
  - gnt[idx]=1; spe=mstr=ctrl_control=sptef=1; reg_addr/reg_wdata = latched values.
  - counter=0. Next state XFER.
  - Latency: req sampled at edge N gives gnt high after edge N+1.
- XFER:
  - gnt, spe, mstr, ctrl_control, reg_addr and reg_wdata all held; counter increments each cycle.
  - txc=1: rdata<=m_rdata, done[idx] pulses for 1 cycle, sptef<=0, next state DONE.
  - counter==TIMEOUT with txc=0: err[idx] pulses, rdata unchanged, next state DONE.
  - txc and timeout in the same cycle: txc wins (done, not err).
- DONE (1 cycle):
  - spe, mstr, ctrl_control, sptef and gnt cleared; rr_ptr <= (idx+1) mod NREQ.
  - Next state IDLE.
  - Gives the controller one cycle with SPE=0 so it returns to IDLE.
- Back-to-back: minimum 4 cycles per transaction (IDLE, GRANT, XFER >=1, DONE).
- Requests during a transaction:
  - Changes to req, req_addr or req_wdata after latching are ignored until DONE.
  - A dropped req does not abort the transfer.
- txc seen in IDLE, GRANT or DONE: ignored.
- A requester that keeps req high after done is re-served only after every other pending requester (fairness via rr_ptr).
- No combinational path from any input to any output.

Decomposition:
- Package spi_arb_pkg: state encoding constants (IDLE=2'b00, GRANT=2'b01, XFER=2'b10, DONE=2'b11) and default DATA/ADDR widths shared with the SPI controller.
- One sub-module: spi_rr_picker. Combinational rotate-priority search; inputs req and rr_ptr; outputs valid and idx.
- The FSM, counter and output registers live in spi_xfer_arbiter.

Test Plan:
- Single request: req=4'b0010, req_addr[1]=3'd5, req_wdata[1]=8'hA5, txc after 10 cycles with m_rdata=8'h3C.
  Response: gnt=4'b0010 one cycle after req; reg_addr=5, reg_wdata=A5, spe=mstr=ctrl_control=sptef=1; done[1] pulse; rdata=8'h3C; spe=0 in DONE.
- Round-robin: req=4'b1111 held, txc returned 3 cycles into each XFER.
  Response: grant order 0,1,2,3,0; each done pulse goes to the matching requester.
- Timeout: TIMEOUT=8, req=4'b0001, txc never asserted.
  Response: err[0] pulse exactly 9 cycles after GRANT (counter 0..8); rdata unchanged; done=0; return to IDLE.
- Simultaneous txc and timeout: txc=1 exactly on counter==TIMEOUT, m_rdata=8'h77.
  Response: done pulse only, rdata=8'h77, err stays 0.
- Reset mid-XFER: drop PRESETn asynchronously while spe=1.
  Response: all outputs 0 immediately, without waiting for a clock edge; rr_ptr=0; after release, pending req=4'b0100 is granted normally.
- Input change during transfer: req_wdata[2] changes from 8'h11 to 8'hFF after GRANT.
  Response: reg_wdata stays 8'h11 until DONE.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI transfer arbiter.
// State encoding and default widths match the SPI controller.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    XFER  = 2'b10,
    DONE  = 2'b11
  } arb_state_e;

  localparam int DEF_DATA = 8;
  localparam int DEF_ADDR = 3;

endpackage

// File: rtl/spi_rr_picker.sv
// Rotating-priority search over the request vector.
// The first set bit at or after rr_ptr_i, wrapping, wins.
module spi_rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic            valid_o,
  output logic [IW-1:0]   idx_o
);

  // Walk from the far end so the nearest offset is assigned last.
  always_comb begin
    int k;
    k       = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(rr_ptr_i) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin owner of one SPI controller: grant, run
// one master transfer, return the byte, pulse done/err.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA    = DEF_DATA,
  parameter int ADDR    = DEF_ADDR,
  parameter int TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 PRESETn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*DATA-1:0] req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [DATA-1:0]      rdata,
  output logic                 busy,
  output logic                 spe,
  output logic                 mstr,
  output logic                 ctrl_control,
  output logic                 sptef,
  output logic [ADDR-1:0]      reg_addr,
  output logic [DATA-1:0]      reg_wdata,
  input  logic                 txc,
  input  logic [DATA-1:0]      m_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [DATA-1:0] rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            spe_q, spe_d;
  logic            mstr_q, mstr_d;
  logic            ctl_q, ctl_d;
  logic            sptef_q, sptef_d;
  logic [ADDR-1:0] raddr_q, raddr_d;
  logic [DATA-1:0] rwdata_q, rwdata_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] oh;

  assign oh = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;

  spi_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_q),
    .valid_o  (pick_vld),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    spe_d    = spe_q;
    mstr_d   = mstr_q;
    ctl_d    = ctl_q;
    sptef_d  = sptef_q;
    raddr_d  = raddr_q;
    rwdata_d = rwdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d   = pick_idx;
          addr_d  = req_addr[pick_idx*ADDR +: ADDR];
          wdata_d = req_wdata[pick_idx*DATA +: DATA];
          state_d = GRANT;
        end
      end
      GRANT: begin
        gnt_d    = oh;
        spe_d    = 1'b1;
        mstr_d   = 1'b1;
        ctl_d    = 1'b1;
        sptef_d  = 1'b1;
        raddr_d  = addr_q;
        rwdata_d = wdata_q;
        cnt_d    = '0;
        state_d  = XFER;
      end
      XFER: begin
        cnt_d = cnt_q + 1'b1;
        // txc has priority over a same-cycle timeout.
        if (txc) begin
          rdata_d = m_rdata;
          done_d  = oh;
          sptef_d = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          err_d   = oh;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        spe_d   = 1'b0;
        mstr_d  = 1'b0;
        ctl_d   = 1'b0;
        sptef_d = 1'b0;
        rr_d    = (idx_q == IW'(NREQ - 1)) ? '0
                                           : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      spe_q    <= 1'b0;
      mstr_q   <= 1'b0;
      ctl_q    <= 1'b0;
      sptef_q  <= 1'b0;
      raddr_q  <= '0;
      rwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      spe_q    <= spe_d;
      mstr_q   <= mstr_d;
      ctl_q    <= ctl_d;
      sptef_q  <= sptef_d;
      raddr_q  <= raddr_d;
      rwdata_q <= rwdata_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign spe          = spe_q;
  assign mstr         = mstr_q;
  assign ctrl_control = ctl_q;
  assign sptef        = sptef_q;
  assign reg_addr     = raddr_q;
  assign reg_wdata    = rwdata_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter, TIMEOUT=8.
// Expected values are hand-derived from the transfer timing.
module tb_spi_xfer_arbiter;

  logic        CLK;
  logic        PRESETn;
  logic [3:0]  req;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  err;
  logic [7:0]  rdata;
  logic        busy;
  logic        spe;
  logic        mstr;
  logic        ctrl_control;
  logic        sptef;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        txc;
  logic [7:0]  m_rdata;

  int total = 0;
  int bad   = 0;
  logic [7:0] last_rd;

  spi_xfer_arbiter #(
    .NREQ    (4),
    .DATA    (8),
    .ADDR    (3),
    .TIMEOUT (8)
  ) dut (
    .CLK          (CLK),
    .PRESETn      (PRESETn),
    .req          (req),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .busy         (busy),
    .spe          (spe),
    .mstr         (mstr),
    .ctrl_control (ctrl_control),
    .sptef        (sptef),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .txc          (txc),
    .m_rdata      (m_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic serve(input int id,
                       input int lat,
                       input logic [7:0] rd,
                       input logic [3:0] req_after,
                       input bit poke);
    int n;
    logic [2:0] ea;
    logic [7:0] ew;
    ea = req_addr[id*3 +: 3];
    ew = req_wdata[id*8 +: 8];
    n = 0;
    while (gnt == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("gnt_lat", n, 2);
    chk("gnt", gnt, 4'b0001 << id);
    chk("ctl_on", {spe, mstr, ctrl_control, sptef}, 4'hF);
    chk("reg_addr", reg_addr, ea);
    chk("reg_wdata", reg_wdata, ew);
    chk("busy", busy, 1);
    if (poke) begin
      req_wdata[id*8 +: 8] = 8'hFF;
      req = 4'b0;
    end
    repeat (lat) begin
      tick();
      chk("hold_wdata", reg_wdata, ew);
      chk("hold_gnt", gnt, 4'b0001 << id);
      chk("no_pulse", {done, err}, 0);
    end
    txc = 1'b1;
    m_rdata = rd;
    tick();
    txc = 1'b0;
    m_rdata = 8'h00;
    req = req_after;
    chk("done", done, 4'b0001 << id);
    chk("no_err", err, 0);
    chk("rdata", rdata, rd);
    chk("sptef_off", sptef, 0);
    chk("spe_held", spe, 1);
    last_rd = rd;
    tick();
    chk("released",
        {gnt, done, spe, mstr, ctrl_control, sptef}, 0);
    chk("idle", busy, 0);
    chk("rdata_kept", rdata, rd);
  endtask

  initial begin
    int n;
    PRESETn   = 1'b0;
    req       = '0;
    req_addr  = '0;
    req_wdata = '0;
    txc       = 1'b0;
    m_rdata   = '0;
    last_rd   = '0;
    #1;
    chk("rst_outs",
        {gnt, done, err, rdata, busy, spe, mstr,
         ctrl_control, sptef, reg_addr, reg_wdata}, 0);
    repeat (2) @(posedge CLK);
    #1;
    PRESETn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      req_addr[i*3 +: 3]  = 3'(i + 1);
      req_wdata[i*8 +: 8] = 8'hA0 + 8'(i);
    end
    req = 4'b1111;
    serve(0, 2, 8'h10, 4'b1111, 0);
    serve(1, 2, 8'h21, 4'b1111, 0);
    serve(2, 2, 8'h32, 4'b1111, 0);
    serve(3, 2, 8'h43, 4'b1111, 0);
    serve(0, 2, 8'h54, 4'b0000, 0);

    req_addr[1*3 +: 3]  = 3'd5;
    req_wdata[1*8 +: 8] = 8'hA5;
    req = 4'b0010;
    serve(1, 5, 8'h3C, 4'b0000, 0);

    req = 4'b0010;
    serve(1, 8, 8'h77, 4'b0000, 0);

    req_wdata[2*8 +: 8] = 8'h11;
    req = 4'b0100;
    serve(2, 3, 8'h99, 4'b0000, 1);

    req = 4'b0001;
    n = 0;
    while (gnt == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("to_gnt", gnt, 4'b0001);
    n = 0;
    while (err == 4'b0 && n < 20) begin
      chk("to_no_done", done, 0);
      tick();
      n++;
    end
    chk("to_cycles", n, 9);
    chk("to_err", err, 4'b0001);
    chk("to_done", done, 0);
    chk("to_rdata", rdata, last_rd);
    req = 4'b0;
    tick();
    chk("to_release", {gnt, err, spe}, 0);
    chk("to_idle", busy, 0);

    req_wdata[2*8 +: 8] = 8'h22;
    req = 4'b0100;
    n = 0;
    while (gnt == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_gnt", gnt, 4'b0100);
    chk("mid_spe", spe, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_outs",
        {gnt, done, err, rdata, busy, spe, mstr,
         ctrl_control, sptef, reg_addr, reg_wdata}, 0);
    #3;
    PRESETn = 1'b1;
    req = 4'b0101;
    serve(0, 1, 8'h5A, 4'b0100, 0);
    serve(2, 1, 8'hC3, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
